mlp_sequencer: RTL and testbench
================================

# mlp_sequencer

Controller for the coffee/air/espresso classifier's 4-6-5-3 MLP datapath. On a start request it latches the selected sensor-sample index and drives one shared multiply-accumulate datapath neuron by neuron: weight/bias ROM addresses, accumulator control, hidden-layer activation, layer-buffer writes and the final sigmoid-LUT pass. The MAC, the layer buffers and the LUT stay in the datapath. This block owns only sequencing and the start/done handshake.

## Interface
- WIDTH, 32: datapath word width. Not used internally; passed through for consistency with the datapath.
- SAMPLE_W, 12: width of the sensor-sample index.
- W_ADDR_W, 7: weight ROM address width (69 weights).
- B_ADDR_W, 4: bias ROM address width (14 biases).

Ports (name, direction, width, meaning):
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  request inference; level-sampled in IDLE only.
- sample_idx_i  in  SAMPLE_W  sensor-sample index; captured when start_i is accepted.
- hold_i  in  1  stall; weight or bias memory not ready.
- sample_addr_o  out  SAMPLE_W  latched sample index, drives the sensor memories.
- busy_o  out  1  high from accept until the DONE cycle, inclusive.
- done_o  out  1  one-cycle pulse; the results are valid.
- layer_o  out  2  current layer: 0, 1 or 2.
- neuron_o  out  3  current output-neuron index within the layer.
- input_o  out  3  current input index within the layer.
- w_addr_o  out  W_ADDR_W  weight ROM address.
- b_addr_o  out  B_ADDR_W  bias ROM address.
- acc_en_o  out  1  MAC cycle; accumulator adds the product.
- acc_clr_o  out  1  with acc_en_o: load the product instead of adding it.
- bias_en_o  out  1  accumulator adds the bias.
- wr_en_o  out  1  write the accumulator to the buffer of the next layer.
- act_en_o  out  1  with wr_en_o: apply leaky ReLU (layers 0 and 1 only).
- sig_en_o  out  1  replace output neuron_o with its sigmoid-LUT value.

## Operation
- Layer sizes:
  - Layer 0: fan-in 4, 6 neurons.
  - Layer 1: fan-in 6, 5 neurons.
  - Layer 2: fan-in 5, 3 neurons.
- Weight order is layer-major, then neuron-major, then input-minor:
  - Layer 0 weights at 0..23, layer 1 at 24..53, layer 2 at 54..68.
  - w_addr_o increments by 1 on every MAC cycle. It is not recomputed.
- Bias order: layer 0 at 0..5, layer 1 at 6..10, layer 2 at 11..13. b_addr_o increments after every BIAS cycle.
- States and transitions:
  - IDLE: if start_i, capture sample_idx_i, clear the counters and go to MAC.
  - MAC: fan-in cycles with input_o counting 0..fan-1. acc_en_o is high throughout; acc_clr_o is high only at input 0. After the last input go to BIAS.
  - BIAS: one cycle with bias_en_o high, then WRITE.
  - WRITE: one cycle with wr_en_o high and act_en_o = (layer_o < 2). Then one of:
    - next neuron → MAC;
    - last neuron of the layer and layer < 2 → next layer, neuron 0, MAC;
    - last neuron of layer 2 → SIGMOID.
  - SIGMOID: 3 cycles with sig_en_o high and neuron_o counting 0..2. Then DONE.
  - DONE: one cycle with done_o and busy_o high. Then IDLE.
- hold_i high in MAC, BIAS, WRITE or SIGMOID:
  - state, counters and addresses are frozen;
  - all strobes are forced low (acc_en, acc_clr, bias_en, wr_en, sig_en);
  - busy_o stays high.
- hold_i has no effect in IDLE or DONE.
- start_i outside IDLE is ignored, including in the DONE cycle. It is not queued.
- sample_addr_o is held until the next accepted start.

## Timing
- Reset (asynchronous, rst low):
  - state goes to IDLE;
  - every output is 0, including sample_addr_o, w_addr_o, b_addr_o, layer_o, neuron_o and input_o.
- Reset mid-run aborts the sequence. No done_o is produced.
- All outputs are registered.
- start_i is accepted at edge k. Then, without holds:
  - the first MAC cycle is k+1;
  - work takes 100 cycles: 36 (layer 0) + 40 (layer 1) + 21 (layer 2) + 3 (sigmoid);
  - done_o is high during cycle k+101.
- Each cycle of hold_i adds exactly one cycle of latency.
- start_i held high continuously starts a new run in the first IDLE cycle after DONE. Period: 102 cycles.

## Structure
- Shared package mlp_pkg holds:
  - the layer fan-in and neuron-count constants;
  - the weight and bias base offsets;
  - the state enum (IDLE, MAC, BIAS, WRITE, SIGMOID, DONE).
- The datapath imports the same constants.
- No sub-module. The FSM and the counters are in a single module.

## Test plan
- Reset, then one start with sample_idx_i=37 and hold_i=0:
  - sample_addr_o = 37;
  - done_o at k+101;
  - 69 acc_en_o cycles with w_addr_o 0..68 in order;
  - 14 bias_en_o cycles with b_addr_o 0..13.
- Strobe pattern in the same run:
  - acc_clr_o exactly 14 times, always with input_o = 0;
  - wr_en_o 14 times; act_en_o on the first 11 of those only;
  - sig_en_o for neuron_o 0, 1, 2.
- hold_i high for 5 cycles at layer 1, neuron 2, input 3:
  - strobes low and addresses frozen during the hold;
  - done_o at k+106.
- start_i pulsed at cycle 50 of a run and again in the DONE cycle: both ignored, busy_o unaffected.
- start_i held high: runs repeat every 102 cycles.
- rst asserted at layer 2, neuron 1:
  - all outputs go to 0 immediately, no done_o;
  - after release, a new start produces a clean 101-cycle run.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared constants for the 4-6-5-3 MLP: layer geometry, ROM base offsets
// and the sequencer state encoding. The datapath imports the same package.
package mlp_pkg;

  localparam int unsigned NUM_LAYERS = 3;

  localparam int unsigned FAN_IN_L0  = 4;
  localparam int unsigned FAN_IN_L1  = 6;
  localparam int unsigned FAN_IN_L2  = 5;

  localparam int unsigned NEURONS_L0 = 6;
  localparam int unsigned NEURONS_L1 = 5;
  localparam int unsigned NEURONS_L2 = 3;

  // Weights are stored layer-major, neuron-major, input-minor.
  localparam int unsigned W_BASE_L0  = 0;
  localparam int unsigned W_BASE_L1  = 24;
  localparam int unsigned W_BASE_L2  = 54;
  localparam int unsigned W_TOTAL    = 69;

  // One bias per neuron, layer-major.
  localparam int unsigned B_BASE_L0  = 0;
  localparam int unsigned B_BASE_L1  = 6;
  localparam int unsigned B_BASE_L2  = 11;
  localparam int unsigned B_TOTAL    = 14;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MAC     = 3'd1,
    ST_BIAS    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_SIGMOID = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Index of the last input of a layer (fan-in minus one).
  function automatic logic [2:0] last_input(input logic [1:0] layer);
    case (layer)
      2'd0:    last_input = 3'(FAN_IN_L0 - 1);
      2'd1:    last_input = 3'(FAN_IN_L1 - 1);
      2'd2:    last_input = 3'(FAN_IN_L2 - 1);
      default: last_input = 3'(FAN_IN_L0 - 1);
    endcase
  endfunction

  // Index of the last neuron of a layer (neuron count minus one).
  function automatic logic [2:0] last_neuron(input logic [1:0] layer);
    case (layer)
      2'd0:    last_neuron = 3'(NEURONS_L0 - 1);
      2'd1:    last_neuron = 3'(NEURONS_L1 - 1);
      2'd2:    last_neuron = 3'(NEURONS_L2 - 1);
      default: last_neuron = 3'(NEURONS_L0 - 1);
    endcase
  endfunction

endpackage

// File: rtl/mlp_sequencer.sv
// Sequencer for the shared MAC datapath of the 4-6-5-3 classifier MLP.
// Every output is a register: the "_s" values computed each cycle describe
// the operation the datapath performs in the following cycle. A stall
// (hold_i in a working state) repeats the current position with all
// strobes low, so each held cycle inserts exactly one idle bubble.
module mlp_sequencer
  import mlp_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned W_ADDR_W = 7,
  parameter int unsigned B_ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [SAMPLE_W-1:0] sample_idx_i,
  input  logic                hold_i,
  output logic [SAMPLE_W-1:0] sample_addr_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          layer_o,
  output logic [2:0]          neuron_o,
  output logic [2:0]          input_o,
  output logic [W_ADDR_W-1:0] w_addr_o,
  output logic [B_ADDR_W-1:0] b_addr_o,
  output logic                acc_en_o,
  output logic                acc_clr_o,
  output logic                bias_en_o,
  output logic                wr_en_o,
  output logic                act_en_o,
  output logic                sig_en_o
);

  // WIDTH is carried only for the datapath; reject geometry that the
  // address ports cannot cover or that disagrees with the base offsets.
  if ((WIDTH < 32'd1) ||
      (W_TOTAL > (32'd1 << W_ADDR_W)) || (B_TOTAL > (32'd1 << B_ADDR_W)) ||
      (W_BASE_L1 != W_BASE_L0 + FAN_IN_L0 * NEURONS_L0) ||
      (W_BASE_L2 != W_BASE_L1 + FAN_IN_L1 * NEURONS_L1) ||
      (W_TOTAL   != W_BASE_L2 + FAN_IN_L2 * NEURONS_L2) ||
      (B_BASE_L1 != B_BASE_L0 + NEURONS_L0) ||
      (B_BASE_L2 != B_BASE_L1 + NEURONS_L1) ||
      (B_TOTAL   != B_BASE_L2 + NEURONS_L2) ||
      (NUM_LAYERS != 32'd3)) begin : g_param_check
    $error("mlp_sequencer: inconsistent layer geometry or address widths");
  end

  state_e              state_r, state_s;
  logic [SAMPLE_W-1:0] sample_r, sample_s;
  logic [1:0]          layer_r, layer_s;
  logic [2:0]          neuron_r, neuron_s;
  logic [2:0]          input_r, input_s;
  logic [W_ADDR_W-1:0] w_addr_r, w_addr_s;
  logic [B_ADDR_W-1:0] b_addr_r, b_addr_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                acc_en_r, acc_en_s;
  logic                acc_clr_r, acc_clr_s;
  logic                bias_en_r, bias_en_s;
  logic                wr_en_r, wr_en_s;
  logic                act_en_r, act_en_s;
  logic                sig_en_r, sig_en_s;
  logic                stall_s;

  // Next position and next-cycle strobes from the current position.
  always_comb begin
    state_s  = state_r;
    sample_s = sample_r;
    layer_s  = layer_r;
    neuron_s = neuron_r;
    input_s  = input_r;
    w_addr_s = w_addr_r;
    b_addr_s = b_addr_r;
    stall_s  = hold_i && (state_r != ST_IDLE) && (state_r != ST_DONE);

    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s  = ST_MAC;
          sample_s = sample_idx_i;
          layer_s  = 2'd0;
          neuron_s = 3'd0;
          input_s  = 3'd0;
          w_addr_s = '0;
          b_addr_s = '0;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (stall_s) begin
          state_s  = ST_MAC;
        end else begin
          w_addr_s = w_addr_r + W_ADDR_W'(1'b1);
          if (input_r == last_input(layer_r)) begin
            state_s = ST_BIAS;
          end else begin
            input_s = input_r + 3'd1;
          end
        end
      end
      ST_BIAS: begin
        if (stall_s) begin
          state_s  = ST_BIAS;
        end else begin
          state_s  = ST_WRITE;
          b_addr_s = b_addr_r + B_ADDR_W'(1'b1);
        end
      end
      ST_WRITE: begin
        if (stall_s) begin
          state_s = ST_WRITE;
        end else if (neuron_r != last_neuron(layer_r)) begin
          state_s  = ST_MAC;
          neuron_s = neuron_r + 3'd1;
          input_s  = 3'd0;
        end else if (layer_r != 2'd2) begin
          state_s  = ST_MAC;
          layer_s  = layer_r + 2'd1;
          neuron_s = 3'd0;
          input_s  = 3'd0;
        end else begin
          state_s  = ST_SIGMOID;
          neuron_s = 3'd0;
        end
      end
      ST_SIGMOID: begin
        if (stall_s) begin
          state_s  = ST_SIGMOID;
        end else if (neuron_r == 3'(NEURONS_L2 - 1)) begin
          state_s  = ST_DONE;
        end else begin
          neuron_s = neuron_r + 3'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    acc_en_s  = !stall_s && (state_s == ST_MAC);
    acc_clr_s = !stall_s && (state_s == ST_MAC) && (input_s == 3'd0);
    bias_en_s = !stall_s && (state_s == ST_BIAS);
    wr_en_s   = !stall_s && (state_s == ST_WRITE);
    act_en_s  = !stall_s && (state_s == ST_WRITE) && (layer_s < 2'd2);
    sig_en_s  = !stall_s && (state_s == ST_SIGMOID);
    done_s    = (state_s == ST_DONE);
    busy_s    = (state_s != ST_IDLE);
  end

  // State, counters and registered outputs; reset aborts any run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      sample_r  <= '0;
      layer_r   <= 2'd0;
      neuron_r  <= 3'd0;
      input_r   <= 3'd0;
      w_addr_r  <= '0;
      b_addr_r  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      acc_en_r  <= 1'b0;
      acc_clr_r <= 1'b0;
      bias_en_r <= 1'b0;
      wr_en_r   <= 1'b0;
      act_en_r  <= 1'b0;
      sig_en_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      sample_r  <= sample_s;
      layer_r   <= layer_s;
      neuron_r  <= neuron_s;
      input_r   <= input_s;
      w_addr_r  <= w_addr_s;
      b_addr_r  <= b_addr_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      acc_en_r  <= acc_en_s;
      acc_clr_r <= acc_clr_s;
      bias_en_r <= bias_en_s;
      wr_en_r   <= wr_en_s;
      act_en_r  <= act_en_s;
      sig_en_r  <= sig_en_s;
    end
  end

  assign sample_addr_o = sample_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign layer_o       = layer_r;
  assign neuron_o      = neuron_r;
  assign input_o       = input_r;
  assign w_addr_o      = w_addr_r;
  assign b_addr_o      = b_addr_r;
  assign acc_en_o      = acc_en_r;
  assign acc_clr_o     = acc_clr_r;
  assign bias_en_o     = bias_en_r;
  assign wr_en_o       = wr_en_r;
  assign act_en_o      = act_en_r;
  assign sig_en_o      = sig_en_r;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer. Cycle n of a run is the n-th clock
// period after the edge that accepts start_i; outputs are sampled on the
// falling edge and inputs driven right after sampling.
module tb_mlp_sequencer;

  logic        clk, rst, start_i, hold_i;
  logic [11:0] sample_idx_i, sample_addr_o;
  logic        busy_o, done_o;
  logic [1:0]  layer_o;
  logic [2:0]  neuron_o, input_o;
  logic [6:0]  w_addr_o;
  logic [3:0]  b_addr_o;
  logic        acc_en_o, acc_clr_o, bias_en_o, wr_en_o, act_en_o, sig_en_o;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_n, clr_n, bias_n, wr_n, act_n, sig_n, done_n, done_c1, done_c2;
  int exp_w, exp_b;

  mlp_sequencer #(.WIDTH(32), .SAMPLE_W(12), .W_ADDR_W(7), .B_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .sample_idx_i(sample_idx_i),
    .hold_i(hold_i), .sample_addr_o(sample_addr_o), .busy_o(busy_o),
    .done_o(done_o), .layer_o(layer_o), .neuron_o(neuron_o),
    .input_o(input_o), .w_addr_o(w_addr_o), .b_addr_o(b_addr_o),
    .acc_en_o(acc_en_o), .acc_clr_o(acc_clr_o), .bias_en_o(bias_en_o),
    .wr_en_o(wr_en_o), .act_en_o(act_en_o), .sig_en_o(sig_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] all_outs();
    return {sample_addr_o, busy_o, done_o, layer_o, neuron_o, input_o, w_addr_o,
            b_addr_o, acc_en_o, acc_clr_o, bias_en_o, wr_en_o, act_en_o, sig_en_o};
  endfunction

  // One run: start with idx, observe ncyc cycles, optional hold window,
  // start pulses, continuous start and mid-run reset.
  task automatic run_seq(input logic [11:0] idx, input int ncyc, input int hold_at,
                         input int hold_len, input int pulse_a, input int pulse_b,
                         input bit keep_start, input int rst_at, input int exp_done);
    acc_n = 0; clr_n = 0; bias_n = 0; wr_n = 0; act_n = 0; sig_n = 0;
    done_n = 0; done_c1 = 0; done_c2 = 0; exp_w = 0; exp_b = 0;
    @(negedge clk);
    start_i = 1'b1;
    sample_idx_i = idx;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      if (done_n == 0) begin
        if (acc_en_o) begin
          check("w_addr_seq", 64'(w_addr_o), 64'(exp_w));
          exp_w++; acc_n++;
        end
        if (acc_clr_o) begin
          check("clr_input0", 64'(input_o), 64'd0);
          clr_n++;
        end
        if (bias_en_o) begin
          check("b_addr_seq", 64'(b_addr_o), 64'(exp_b));
          exp_b++; bias_n++;
        end
        if (wr_en_o) begin
          check("act_on_write", 64'(act_en_o), 64'(wr_n < 11));
          wr_n++;
        end
        if (act_en_o) act_n++;
        if (sig_en_o) begin
          check("sig_neuron", 64'(neuron_o), 64'(sig_n));
          sig_n++;
        end
      end
      if (done_o) begin
        if (done_n == 0) done_c1 = cyc; else done_c2 = cyc;
        done_n++;
      end
      if (exp_done > 0 && cyc <= exp_done + 1)
        check("busy", 64'(busy_o), 64'(cyc <= exp_done));
      if (hold_at > 0 && cyc == hold_at)
        check("hold_pos", 64'({layer_o, neuron_o, input_o, w_addr_o}), 64'({2'd1, 3'd2, 3'd3, 7'd39}));
      if (hold_at > 0 && cyc > hold_at && cyc <= hold_at + hold_len) begin
        check("hold_strobes", 64'({acc_en_o, acc_clr_o, bias_en_o, wr_en_o, sig_en_o}), 64'd0);
        check("hold_frozen", 64'({layer_o, neuron_o, input_o, w_addr_o, b_addr_o}),
              64'({2'd1, 3'd2, 3'd3, 7'd39, 4'd8}));
      end
      if (hold_at > 0 && cyc == hold_at + hold_len + 1)
        check("hold_resume", 64'({acc_en_o, input_o, w_addr_o}), 64'({1'b1, 3'd4, 7'd40}));
      start_i = keep_start || (cyc == pulse_a) || (cyc == pulse_b);
      hold_i  = (hold_at > 0) && (cyc >= hold_at) && (cyc < hold_at + hold_len);
      if (rst_at > 0 && cyc == rst_at) begin
        check("rst_pos", 64'({layer_o, neuron_o}), 64'({2'd2, 3'd1}));
        rst = 1'b0;
        #1;
        check("rst_async_zero", 64'(all_outs()), 64'd0);
      end
    end
    start_i = 1'b0;
    hold_i  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; hold_i = 1'b0; sample_idx_i = 12'd0;
    #2;
    check("reset_outs", 64'(all_outs()), 64'd0);
    @(negedge clk);
    start_i = 1'b1; sample_idx_i = 12'd99;
    @(negedge clk);
    check("reset_ignores_start", 64'(all_outs()), 64'd0);
    start_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'(all_outs()), 64'd0);

    // Plain run.
    run_seq(12'd37, 103, 0, 0, 0, 0, 1'b0, 0, 101);
    check("sample_addr", 64'(sample_addr_o), 64'd37);
    check("done_cycle", 64'(done_c1), 64'd101);
    check("done_count", 64'(done_n), 64'd1);
    check("acc_count", 64'(acc_n), 64'd69);
    check("clr_count", 64'(clr_n), 64'd14);
    check("bias_count", 64'(bias_n), 64'd14);
    check("wr_count", 64'(wr_n), 64'd14);
    check("act_count", 64'(act_n), 64'd11);
    check("sig_count", 64'(sig_n), 64'd3);

    // Five-cycle hold at layer 1, neuron 2, input 3.
    run_seq(12'd100, 108, 56, 5, 0, 0, 1'b0, 0, 106);
    check("hold_done_cycle", 64'(done_c1), 64'd106);
    check("hold_acc_count", 64'(acc_n), 64'd69);
    check("hold_bias_count", 64'(bias_n), 64'd14);
    check("hold_sample_addr", 64'(sample_addr_o), 64'd100);

    // start_i pulses mid-run and in the DONE cycle are ignored.
    run_seq(12'd7, 105, 0, 0, 50, 101, 1'b0, 0, 101);
    check("pulse_done_cycle", 64'(done_c1), 64'd101);
    check("pulse_done_count", 64'(done_n), 64'd1);
    check("pulse_idle_after", 64'(busy_o), 64'd0);
    check("pulse_sample_addr", 64'(sample_addr_o), 64'd7);

    // start_i held high: back-to-back runs with a 102-cycle period.
    run_seq(12'd5, 203, 0, 0, 0, 0, 1'b1, 0, 101);
    check("cont_done1", 64'(done_c1), 64'd101);
    check("cont_done2", 64'(done_c2), 64'd203);
    @(negedge clk);
    @(negedge clk);
    check("cont_idle_after", 64'(busy_o), 64'd0);

    // Reset at layer 2, neuron 1 aborts the run.
    run_seq(12'd9, 95, 0, 0, 0, 0, 1'b0, 85, 0);
    check("rst_no_done", 64'(done_n), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_idle", 64'(all_outs()), 64'd0);
    run_seq(12'd21, 103, 0, 0, 0, 0, 1'b0, 0, 101);
    check("post_rst_done", 64'(done_c1), 64'd101);
    check("post_rst_acc", 64'(acc_n), 64'd69);
    check("post_rst_sample", 64'(sample_addr_o), 64'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
